dense_feed_ctrl: RTL and testbench

Initiator for the dense layer's weight-load port and feature input. Accepts a serial weight stream and a serial feature stream over valid/ready handshakes. Packs `DENSE_KSIZE` weights per input position into one load write. After all weights are loaded, it presents features on `x` phase-aligned to the dense layer's free-running accumulation counter, so each frame of SIZE features lands on counter values 0..SIZE-1.

---
 rtl/dense_feed_if.sv | 46 ++++
 rtl/dense_feed_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dense_feed_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_feed_if.sv
// Handshake and load-port bundle for dense_feed_ctrl.
// master: the controller; slave: weight/feature sources and dense layer.
`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef DENSE_KSIZE
`define DENSE_KSIZE 10
`endif

interface dense_feed_if #(
   parameter int BIT_DATA = `BIT_DATA,
   parameter int KSIZE    = `DENSE_KSIZE,
   parameter int SIZE     = 128
);
   localparam int BIT_IN = BIT_DATA * KSIZE;
   localparam int AW0    = $clog2(KSIZE);
   localparam int AW1    = $clog2(SIZE);

   logic                       start;
   logic                       w_valid;
   logic                       w_ready;
   logic signed [BIT_DATA-1:0] w_data;
   logic                       x_valid;
   logic                       x_ready;
   logic signed [BIT_DATA-1:0] x_data;
   logic                       load;
   logic [AW0-1:0]             addr0;
   logic [AW1-1:0]             addr1;
   logic signed [BIT_IN-1:0]   w;
   logic signed [BIT_DATA-1:0] x;
   logic                       frame_start;
   logic                       underrun;
   logic                       busy;

   modport master (
      input  start, w_valid, w_data, x_valid, x_data,
      output w_ready, x_ready, load, addr0, addr1, w, x,
      output frame_start, underrun, busy
   );

   modport slave (
      output start, w_valid, w_data, x_valid, x_data,
      input  w_ready, x_ready, load, addr0, addr1, w, x,
      input  frame_start, underrun, busy
   );
endinterface

// File: rtl/dense_feed_ctrl.sv
// Packs a serial weight stream into dense-layer load writes, then streams
// features on x phase-aligned to the layer's free-running counter.
// Ports: clk, rst (async, active-high); bus (dense_feed_if.master):
//   start, w_valid/w_ready/w_data, x_valid/x_ready/x_data in/handshake;
//   load, addr0, addr1, w, x, frame_start, underrun, busy out.
`ifndef BIT_DATA
`define BIT_DATA 8
`endif
`ifndef DENSE_KSIZE
`define DENSE_KSIZE 10
`endif

module dense_feed_ctrl #(
   parameter int BIT_DATA = `BIT_DATA,
   parameter int KSIZE    = `DENSE_KSIZE,
   parameter int SIZE     = 128
) (
   input  logic         clk,
   input  logic         rst,
   dense_feed_if.master bus
);
   localparam int BIT_IN = BIT_DATA * KSIZE;
   localparam int AW0    = $clog2(KSIZE);
   localparam int AW1    = $clog2(SIZE);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_ALIGN   = 3'd3;
   localparam logic [2:0] S_STREAM  = 3'd4;

   localparam logic [AW0-1:0] LANE_LAST = AW0'(KSIZE - 1);
   localparam logic [AW1-1:0] POS_LAST  = AW1'(SIZE - 1);

   logic [2:0]          state_q, state_d;
   logic [AW1-1:0]      pos_q, pos_d;
   logic [AW0-1:0]      lane_q, lane_d;
   logic [AW1-1:0]      mc_q, mc_d;
   logic [BIT_IN-1:0]   lanes_q, lanes_d;
   logic                load_q, load_d;
   logic [AW0-1:0]      addr0_q, addr0_d;
   logic [AW1-1:0]      addr1_q, addr1_d;
   logic [BIT_IN-1:0]   w_q, w_d;
   logic [BIT_DATA-1:0] x_q, x_d;
   logic                fs_q, fs_d;
   logic                under_q, under_d;
   logic                busy_q, busy_d;
   logic                w_rdy, x_rdy;
   logic                w_acc, x_acc;

   assign w_rdy = (state_q == S_COLLECT);
   assign x_rdy = (state_q == S_STREAM);
   assign w_acc = w_rdy & bus.w_valid;
   assign x_acc = x_rdy & bus.x_valid;

   // Copy of the dense layer's counter: it freezes only on load cycles.
   always_comb begin
      mc_d = mc_q;
      if (!load_q) begin
         mc_d = (mc_q == POS_LAST) ? '0 : mc_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      lane_d  = lane_q;
      lanes_d = lanes_q;
      load_d  = 1'b0;
      addr0_d = addr0_q;
      addr1_d = addr1_q;
      w_d     = w_q;
      x_d     = '0;
      fs_d    = 1'b0;
      under_d = under_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_COLLECT;
               pos_d   = '0;
               lane_d  = '0;
            end
         end
         S_COLLECT: begin
            if (w_acc) begin
               lanes_d[int'(lane_q)*BIT_DATA +: BIT_DATA] = bus.w_data;
               if (lane_q == LANE_LAST) begin
                  lane_d  = '0;
                  state_d = S_WRITE;
                  load_d  = 1'b1;
                  addr0_d = LANE_LAST;
                  addr1_d = pos_q;
                  w_d     = lanes_d;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (pos_q == POS_LAST) begin
               state_d = S_ALIGN;
            end else begin
               pos_d   = pos_q + 1'b1;
               state_d = S_COLLECT;
            end
         end
         S_ALIGN: begin
            // Stream starts when the counter is about to read SIZE-1:
            // that cycle's feature is registered onto x as it wraps to 0.
            if (mc_d == POS_LAST) state_d = S_STREAM;
         end
         S_STREAM: begin
            x_d     = x_acc ? bus.x_data : '0;
            under_d = under_q | ~x_acc;
            fs_d    = (mc_d == '0);
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pos_q   <= '0;
         lane_q  <= '0;
         mc_q    <= '0;
         lanes_q <= '0;
         load_q  <= 1'b0;
         addr0_q <= '0;
         addr1_q <= '0;
         w_q     <= '0;
         x_q     <= '0;
         fs_q    <= 1'b0;
         under_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         lane_q  <= lane_d;
         mc_q    <= mc_d;
         lanes_q <= lanes_d;
         load_q  <= load_d;
         addr0_q <= addr0_d;
         addr1_q <= addr1_d;
         w_q     <= w_d;
         x_q     <= x_d;
         fs_q    <= fs_d;
         under_q <= under_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.w_ready     = w_rdy;
   assign bus.x_ready     = x_rdy;
   assign bus.load        = load_q;
   assign bus.addr0       = addr0_q;
   assign bus.addr1       = addr1_q;
   assign bus.w           = w_q;
   assign bus.x           = x_q;
   assign bus.frame_start = fs_q;
   assign bus.underrun    = under_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_dense_feed_ctrl.sv
// Self-checking bench for dense_feed_ctrl: load table, alignment,
// underrun, reset and randomized sources against a scoreboard model.
module tb_dense_feed_ctrl;
   localparam int BD = 8;
   localparam int K  = 10;
   localparam int SZ = 4;
   localparam int BI = BD * K;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dense_feed_if #(.BIT_DATA(BD), .KSIZE(K), .SIZE(SZ)) bus ();

   dense_feed_ctrl #(.BIT_DATA(BD), .KSIZE(K), .SIZE(SZ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [K-1:0][BD-1:0] lane_in;
      int                   a1;
      logic [BI-1:0]        w_exp;
   } ld_vec_t;

   ld_vec_t tbl [SZ];

   int n_pass = 0;
   int n_chk  = 0;

   // source state
   logic [BD-1:0] wsrc [$];
   int  w_idx  = 0;
   int  w_hold = 0;
   bit  w_rnd  = 0;
   bit  w_fire = 0;
   bit  x_on   = 0;
   bit  x_rnd  = 0;
   int  x_drop = 0;

   // scoreboard state
   bit            mon_en = 0;
   logic [BD-1:0] wq [$];
   int            loads_seen = 0;
   bit            exp_load   = 0;
   bit            prev_load  = 0;
   int            dcnt       = 0;
   bit            prev_xr    = 0;
   bit            prev_xv    = 0;
   logic [BD-1:0] prev_xd    = '0;
   bit            exp_under  = 0;
   bit            exp_busy   = 0;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [BI-1:0] pack(input int p);
      logic [BI-1:0] r;
      r = '0;
      for (int k = 0; k < K; k++) begin
         if (p * K + k < wq.size()) r[k*BD +: BD] = wq[p*K+k];
      end
      return r;
   endfunction

   // Scoreboard: outputs checked at negedge, handshakes recorded for the
   // upcoming rising edge.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (!prev_load) dcnt = (dcnt + 1) % SZ;
         check("load", bus.load, exp_load);
         if (bus.load) begin
            check("addr1", bus.addr1, loads_seen % SZ);
            check("addr0", bus.addr0, K - 1);
            check("w_pack", $unsigned(bus.w), pack(loads_seen));
            check("w_ready_in_load", bus.w_ready, 0);
            loads_seen++;
         end
         check("x", $unsigned(bus.x), (prev_xr && prev_xv) ? prev_xd : '0);
         check("frame_start", bus.frame_start, prev_xr && dcnt == 0);
         check("underrun", bus.underrun, exp_under);
         check("busy", bus.busy, exp_busy);
         if (bus.x_ready && !prev_xr) begin
            check("align_cnt", dcnt, SZ - 1);
            check("align_loads", loads_seen, SZ);
         end
         if (prev_xr) check("x_ready_hold", bus.x_ready, 1);
         w_fire   = bus.w_valid && bus.w_ready;
         exp_load = 0;
         if (w_fire) begin
            wq.push_back(bus.w_data);
            if (wq.size() % K == 0) exp_load = 1;
         end
         if (bus.x_ready && !bus.x_valid) exp_under = 1;
         if (bus.start) exp_busy = 1;
         prev_xr   = bus.x_ready;
         prev_xv   = bus.x_valid;
         prev_xd   = bus.x_data;
         prev_load = bus.load;
      end
   end

   // Sources. Feature data is positional: the value landing on counter
   // value c is c+1, whether or not earlier slots were dropped.
   always @(posedge clk) begin
      #1;
      if (w_fire) w_idx++;
      w_fire = 0;
      bus.w_valid = (w_idx < wsrc.size()) && (w_hold == 0) &&
                    (!w_rnd || $urandom_range(0, 3) != 0);
      if (w_hold > 0) w_hold--;
      bus.w_data = (w_idx < wsrc.size()) ? wsrc[w_idx] : '0;
      bus.x_valid = x_on && (x_drop == 0) &&
                    (!x_rnd || $urandom_range(0, 7) != 0);
      if (x_drop > 0) x_drop--;
      bus.x_data = BD'((dcnt + 2) % SZ + 1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input bit with_start);
      mon_en = 0;
      rst    = 1'b1;
      x_on = 0; x_rnd = 0; w_rnd = 0; w_hold = 0; x_drop = 0;
      wsrc.delete(); w_idx = 0; w_fire = 0;
      wq.delete(); loads_seen = 0; exp_load = 0; prev_load = 0;
      dcnt = 0; prev_xr = 0; prev_xv = 0; prev_xd = '0;
      exp_under = 0; exp_busy = 0;
      tick();
      bus.start = with_start;
      tick();
      bus.start = 1'b0;
      tick();
      rst    = 1'b0;
      mon_en = 1;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_load(input int budget, output bit seen,
                            output int nrdy);
      seen = 0;
      nrdy = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.load) begin
            seen = 1;
            break;
         end
         if (bus.w_ready) nrdy++;
      end
   endtask

   task automatic wait_fs(input int budget, output bit seen);
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.frame_start) begin
            seen = 1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int nr;
      bus.start = 1'b0; bus.w_valid = 1'b0; bus.w_data = '0;
      bus.x_valid = 1'b0; bus.x_data = '0;
      for (int p = 0; p < SZ; p++) begin
         tbl[p].a1    = p;
         tbl[p].w_exp = '0;
         for (int k = 0; k < K; k++) begin
            tbl[p].lane_in[k]          = BD'(p * K + k);
            tbl[p].w_exp[k*BD +: BD]   = BD'(p * K + k);
         end
      end

      // reset with a start pulse inside it
      do_reset(1);
      repeat (5) tick();
      check("rst_load", bus.load, 0);
      check("rst_addr0", bus.addr0, 0);
      check("rst_addr1", bus.addr1, 0);
      check("rst_w", $unsigned(bus.w), 0);
      check("rst_x", $unsigned(bus.x), 0);
      check("rst_fs", bus.frame_start, 0);
      check("rst_under", bus.underrun, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_w_ready", bus.w_ready, 0);
      check("rst_x_ready", bus.x_ready, 0);

      // ideal ramp load, table driven
      for (int p = 0; p < SZ; p++)
         for (int k = 0; k < K; k++) wsrc.push_back(tbl[p].lane_in[k]);
      pulse_start();
      for (int p = 0; p < SZ; p++) begin
         wait_load(40, ok, nr);
         check("ramp_seen", ok, 1);
         check("ramp_addr1", bus.addr1, tbl[p].a1);
         check("ramp_w", $unsigned(bus.w), tbl[p].w_exp);
         check("ramp_gap", nr, K);
      end

      // alignment
      x_on = 1;
      wait_fs(3 * SZ + 4, ok);
      check("fs_first_seen", ok, 1);
      check("fs_first_x", $unsigned(bus.x), 1);
      check("fs_first_cnt", dcnt, 0);
      for (int f = 0; f < 3; f++) begin
         repeat (SZ) tick();
         check("fs_period", bus.frame_start, 1);
         check("fs_period_x", $unsigned(bus.x), 1);
      end

      // single dropped feature
      repeat (2) tick();
      x_drop = 1;
      ok = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.underrun) begin
            ok = 1;
            break;
         end
      end
      check("under_seen", ok, 1);
      check("under_x", $unsigned(bus.x), 0);
      wait_fs(SZ + 1, ok);
      check("under_fs_seen", ok, 1);
      check("under_fs_x", $unsigned(bus.x), 1);
      check("under_sticky", bus.underrun, 1);

      // reset mid-stream
      do_reset(0);
      tick();
      check("mid_x", $unsigned(bus.x), 0);
      check("mid_under", bus.underrun, 0);
      check("mid_busy", bus.busy, 0);
      check("mid_x_ready", bus.x_ready, 0);

      // ramp again with a 3-cycle source stall mid-lane
      for (int p = 0; p < SZ; p++)
         for (int k = 0; k < K; k++) wsrc.push_back(tbl[p].lane_in[k]);
      pulse_start();
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (wq.size() >= K + 5) begin
            ok = 1;
            break;
         end
      end
      check("stall_reach", ok, 1);
      w_hold = 3;
      for (int p = 1; p < SZ; p++) begin
         wait_load(60, ok, nr);
         check("stall_seen", ok, 1);
         check("stall_addr1", bus.addr1, tbl[p].a1);
         check("stall_w", $unsigned(bus.w), tbl[p].w_exp);
      end
      x_on = 1;
      repeat (3 * SZ) tick();

      // random weights, reset part way through the load
      do_reset(0);
      for (int i = 0; i < SZ * K; i++) wsrc.push_back(BD'($urandom));
      w_rnd = 1;
      pulse_start();
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wq.size() >= 2 * K + 3) begin
            ok = 1;
            break;
         end
      end
      check("rnd_partial", ok, 1);
      do_reset(0);
      tick();
      check("rnd_rst_busy", bus.busy, 0);

      // random full reload and random stream drops
      for (int i = 0; i < SZ * K; i++) wsrc.push_back(BD'($urandom));
      w_rnd = 1;
      pulse_start();
      for (int p = 0; p < SZ; p++) begin
         wait_load(200, ok, nr);
         check("rnd_load_seen", ok, 1);
      end
      x_on  = 1;
      x_rnd = 1;
      repeat (15 * SZ) tick();
      check("rnd_loads", loads_seen, SZ);
      check("rnd_stream", bus.x_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
